decode_pipe: RTL and testbench

DECODE_PIPE -- requirements
Module: decode_pipe

---
 rtl/decode_pipe.sv | 162 ++++++++++++++++
 tb/tb_decode_pipe.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_pipe.sv
// Decode stage: register file, opcode decode and ID/EX register.
// Stalls fetch on a load-use hazard and squashes decode on flush.
module decode_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned BYPASS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_valid,
  input  logic [WIDTH-1:0] if_pc,
  input  logic [31:0]      if_instr,
  input  logic             wb_we,
  input  logic [4:0]       wb_reg,
  input  logic [WIDTH-1:0] wb_data,
  input  logic             flush,
  output logic             stall,
  output logic             ex_valid,
  output logic [WIDTH-1:0] ex_pc,
  output logic [WIDTH-1:0] ex_rdata1,
  output logic [WIDTH-1:0] ex_rdata2,
  output logic [WIDTH-1:0] ex_imm,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [4:0]       ex_rd,
  output logic [8:0]       ex_ctrl,
  output logic             ex_illegal
);

  localparam int unsigned IdxW = (NREG > 1) ? $clog2(NREG) : 1;

  localparam logic [5:0] OpRType = 6'h00;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;

  logic [5:0]      w_op;
  logic [4:0]      w_rs;
  logic [4:0]      w_rt;
  logic [4:0]      w_rd;
  logic [IdxW-1:0] w_rs_idx;
  logic [IdxW-1:0] w_rt_idx;
  logic [IdxW-1:0] w_wb_idx;
  logic [WIDTH-1:0] w_rdata1;
  logic [WIDTH-1:0] w_rdata2;
  logic [WIDTH-1:0] w_imm;
  logic [8:0]      w_ctrl;
  logic            w_illegal;
  logic            w_uses_rt;
  logic            w_hazard;
  logic            w_bubble;

  logic [WIDTH-1:0] r_regs [NREG];

  logic             r_ex_valid;
  logic [WIDTH-1:0] r_ex_pc;
  logic [WIDTH-1:0] r_ex_rdata1;
  logic [WIDTH-1:0] r_ex_rdata2;
  logic [WIDTH-1:0] r_ex_imm;
  logic [4:0]       r_ex_rs;
  logic [4:0]       r_ex_rt;
  logic [4:0]       r_ex_rd;
  logic [8:0]       r_ex_ctrl;
  logic             r_ex_illegal;

  assign w_op     = if_instr[31:26];
  assign w_rs     = if_instr[25:21];
  assign w_rt     = if_instr[20:16];
  assign w_rd     = if_instr[15:11];
  assign w_rs_idx = w_rs[IdxW-1:0];
  assign w_rt_idx = w_rt[IdxW-1:0];
  assign w_wb_idx = wb_reg[IdxW-1:0];
  assign w_imm    = {{(WIDTH-16){if_instr[15]}}, if_instr[15:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (wb_we && (w_wb_idx != '0)) begin
      r_regs[w_wb_idx] <= wb_data;
    end
  end

  // Register 0 is hardwired; forwarding lets a same-cycle writeback reach decode.
  always_comb begin
    w_rdata1 = r_regs[w_rs_idx];
    if (w_rs_idx == '0) begin
      w_rdata1 = '0;
    end else if ((BYPASS != 0) && wb_we && (w_wb_idx == w_rs_idx)) begin
      w_rdata1 = wb_data;
    end
  end

  always_comb begin
    w_rdata2 = r_regs[w_rt_idx];
    if (w_rt_idx == '0) begin
      w_rdata2 = '0;
    end else if ((BYPASS != 0) && wb_we && (w_wb_idx == w_rt_idx)) begin
      w_rdata2 = wb_data;
    end
  end

  always_comb begin
    w_ctrl    = '0;
    w_illegal = 1'b0;
    case (w_op)
      OpRType: w_ctrl = 9'b1_0_0_0_10_0_0_1;
      OpLw:    w_ctrl = 9'b0_0_1_1_00_0_1_1;
      OpSw:    w_ctrl = 9'b0_0_0_0_00_1_1_0;
      OpBeq:   w_ctrl = 9'b0_1_0_0_01_0_0_0;
      OpAddi:  w_ctrl = 9'b0_0_0_0_00_0_1_1;
      default: w_illegal = 1'b1;
    endcase
  end

  // Only R-type, sw and beq actually consume rt as a source operand.
  assign w_uses_rt = (w_op == OpRType) || (w_op == OpSw) || (w_op == OpBeq);
  assign w_hazard  = if_valid && r_ex_valid && r_ex_ctrl[6] && (r_ex_rt != 5'd0) &&
                     ((r_ex_rt == w_rs) || ((r_ex_rt == w_rt) && w_uses_rt));
  assign w_bubble  = flush || !if_valid || w_hazard;
  assign stall     = w_hazard && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex_valid   <= 1'b0;
      r_ex_pc      <= '0;
      r_ex_rdata1  <= '0;
      r_ex_rdata2  <= '0;
      r_ex_imm     <= '0;
      r_ex_rs      <= '0;
      r_ex_rt      <= '0;
      r_ex_rd      <= '0;
      r_ex_ctrl    <= '0;
      r_ex_illegal <= 1'b0;
    end else begin
      r_ex_valid   <= !w_bubble;
      r_ex_ctrl    <= w_bubble ? 9'd0 : w_ctrl;
      r_ex_illegal <= !w_bubble && w_illegal;
      r_ex_pc      <= if_pc;
      r_ex_rdata1  <= w_rdata1;
      r_ex_rdata2  <= w_rdata2;
      r_ex_imm     <= w_imm;
      r_ex_rs      <= w_rs;
      r_ex_rt      <= w_rt;
      r_ex_rd      <= w_rd;
    end
  end

  assign ex_valid   = r_ex_valid;
  assign ex_pc      = r_ex_pc;
  assign ex_rdata1  = r_ex_rdata1;
  assign ex_rdata2  = r_ex_rdata2;
  assign ex_imm     = r_ex_imm;
  assign ex_rs      = r_ex_rs;
  assign ex_rt      = r_ex_rt;
  assign ex_rd      = r_ex_rd;
  assign ex_ctrl    = r_ex_ctrl;
  assign ex_illegal = r_ex_illegal;

endmodule

// File: tb/tb_decode_pipe.sv
// Bench for decode_pipe: directed scenarios plus randomized traffic against a
// behavioural model; a BYPASS=0 copy runs alongside on the same inputs.
module tb_decode_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_valid = 1'b0;
  logic [31:0] if_pc = '0;
  logic [31:0] if_instr = '0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_reg = '0;
  logic [31:0] wb_data = '0;
  logic        flush = 1'b0;

  logic        stall_a, ex_valid_a, ex_illegal_a;
  logic [31:0] ex_pc_a, ex_rdata1_a, ex_rdata2_a, ex_imm_a;
  logic [4:0]  ex_rs_a, ex_rt_a, ex_rd_a;
  logic [8:0]  ex_ctrl_a;
  logic        stall_b, ex_valid_b, ex_illegal_b;
  logic [31:0] ex_pc_b, ex_rdata1_b, ex_rdata2_b, ex_imm_b;
  logic [4:0]  ex_rs_b, ex_rt_b, ex_rd_b;
  logic [8:0]  ex_ctrl_b;

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decode_pipe #(.WIDTH(32), .NREG(32), .BYPASS(1)) u_dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data), .flush(flush),
    .stall(stall_a), .ex_valid(ex_valid_a), .ex_pc(ex_pc_a), .ex_rdata1(ex_rdata1_a),
    .ex_rdata2(ex_rdata2_a), .ex_imm(ex_imm_a), .ex_rs(ex_rs_a), .ex_rt(ex_rt_a),
    .ex_rd(ex_rd_a), .ex_ctrl(ex_ctrl_a), .ex_illegal(ex_illegal_a)
  );

  decode_pipe #(.WIDTH(32), .NREG(32), .BYPASS(0)) u_dut_nb (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data), .flush(flush),
    .stall(stall_b), .ex_valid(ex_valid_b), .ex_pc(ex_pc_b), .ex_rdata1(ex_rdata1_b),
    .ex_rdata2(ex_rdata2_b), .ex_imm(ex_imm_b), .ex_rs(ex_rs_b), .ex_rt(ex_rt_b),
    .ex_rd(ex_rd_b), .ex_ctrl(ex_ctrl_b), .ex_illegal(ex_illegal_b)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural register contents and the expected EX slot.
  logic [31:0] m_regs [32];
  logic        m_valid = 1'b0, m_ill = 1'b0, m_last_stall = 1'b0;
  logic [8:0]  m_ctrl = '0;
  logic [31:0] m_pc = '0, m_r1 = '0, m_r2 = '0, m_r1nb = '0, m_r2nb = '0, m_imm = '0;
  logic [4:0]  m_rs = '0, m_rt = '0, m_rd = '0;

  // Returns {illegal, ctrl} for an opcode from the instruction-set table.
  function automatic logic [9:0] ref_decode(input logic [5:0] op);
    case (op)
      6'h00:   return {1'b0, 9'h111};
      6'h23:   return {1'b0, 9'h063};
      6'h2B:   return {1'b0, 9'h006};
      6'h04:   return {1'b0, 9'h088};
      6'h08:   return {1'b0, 9'h003};
      default: return {1'b1, 9'h000};
    endcase
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] idx, input bit byp);
    if (idx == 5'd0) return 32'd0;
    if (byp && wb_we && (wb_reg == idx)) return wb_data;
    return m_regs[idx];
  endfunction

  function automatic bit ref_stall();
    logic [5:0] op;
    bit reads_rt;
    op = if_instr[31:26];
    reads_rt = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
    if (reset || flush || !if_valid) return 1'b0;
    if (!(m_valid && m_ctrl[6]) || (m_rt == 5'd0)) return 1'b0;
    return (m_rt == if_instr[25:21]) || (reads_rt && (m_rt == if_instr[20:16]));
  endfunction

  always @(posedge clk or posedge reset) begin : model
    bit st;
    bit bub;
    logic [9:0] d;
    if (reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= '0;
      m_valid <= 1'b0; m_ill <= 1'b0; m_ctrl <= '0; m_last_stall <= 1'b0;
      m_pc <= '0; m_r1 <= '0; m_r2 <= '0; m_r1nb <= '0; m_r2nb <= '0; m_imm <= '0;
      m_rs <= '0; m_rt <= '0; m_rd <= '0;
    end else begin
      st  = ref_stall();
      bub = flush || !if_valid || ref_stall() || (flush && if_valid);
      if (!flush && if_valid && !st) bub = 1'b0;
      d   = ref_decode(if_instr[31:26]);
      m_last_stall <= st;
      m_valid <= !bub;
      m_ctrl  <= bub ? 9'd0 : d[8:0];
      m_ill   <= !bub && d[9];
      m_pc    <= if_pc;
      m_r1    <= ref_read(if_instr[25:21], 1'b1);
      m_r2    <= ref_read(if_instr[20:16], 1'b1);
      m_r1nb  <= ref_read(if_instr[25:21], 1'b0);
      m_r2nb  <= ref_read(if_instr[20:16], 1'b0);
      m_imm   <= {{16{if_instr[15]}}, if_instr[15:0]};
      m_rs    <= if_instr[25:21];
      m_rt    <= if_instr[20:16];
      m_rd    <= if_instr[15:11];
      if (wb_we && (wb_reg != 5'd0)) m_regs[wb_reg] <= wb_data;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_stall", stall_a, 0);
      chk("rst_valid", ex_valid_a, 0);
      chk("rst_ctrl", ex_ctrl_a, 0);
      chk("rst_rdata1", ex_rdata1_a, 0);
      chk("rst_pc", ex_pc_a, 0);
    end else begin
      chk("stall", stall_a, ref_stall());
      chk("stall_nb", stall_b, ref_stall());
      chk("ex_valid", ex_valid_a, m_valid);
      chk("ex_ctrl", ex_ctrl_a, m_ctrl);
      chk("ex_illegal", ex_illegal_a, m_ill);
      chk("ex_valid_nb", ex_valid_b, m_valid);
      chk("ex_ctrl_nb", ex_ctrl_b, m_ctrl);
      if (m_valid) begin
        chk("ex_pc", ex_pc_a, m_pc);
        chk("ex_rdata1", ex_rdata1_a, m_r1);
        chk("ex_rdata2", ex_rdata2_a, m_r2);
        chk("ex_imm", ex_imm_a, m_imm);
        chk("ex_rs", ex_rs_a, m_rs);
        chk("ex_rt", ex_rt_a, m_rt);
        chk("ex_rd", ex_rd_a, m_rd);
        chk("ex_rdata1_nb", ex_rdata1_b, m_r1nb);
        chk("ex_rdata2_nb", ex_rdata2_b, m_r2nb);
      end
    end
  end

  task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] instr,
                       input bit we, input logic [4:0] wr, input logic [31:0] wd, input bit fl);
    if_valid = v; if_pc = pc; if_instr = instr;
    wb_we = we; wb_reg = wr; wb_data = wd; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] op;
    logic [4:0] rs, rt, rd;
    case ($urandom_range(0, 9))
      0, 1:    op = 6'h00;
      2, 3, 7: op = 6'h23;
      4:       op = 6'h2B;
      5:       op = 6'h04;
      6:       op = 6'h08;
      default: op = 6'($urandom_range(0, 63));
    endcase
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 31));
    return {op, rs, rt, rd, 11'($urandom)};
  endfunction

  initial begin
    logic [31:0] pc;
    tick(); tick();
    chk("reset_valid", ex_valid_a, 0);
    chk("reset_ctrl", ex_ctrl_a, 0);
    chk("reset_stall", stall_a, 0);
    reset = 1'b0;

    // Writeback r5, then add r3,r5,r0 reads it.
    drive(0, 0, 0, 1, 5, 32'h1234, 0); tick();
    drive(1, 32'h100, 32'h00A01820, 0, 0, 0, 0); tick();
    chk("add_valid", ex_valid_a, 1);
    chk("add_rdata1", ex_rdata1_a, 32'h1234);
    chk("add_rdata2", ex_rdata2_a, 0);
    chk("add_ctrl", ex_ctrl_a, 9'h111);
    chk("add_rd", ex_rd_a, 3);

    // sw r7,-4(r2) with a same-cycle write of r7.
    drive(0, 0, 0, 1, 7, 32'h1111, 0); tick();
    drive(1, 32'h104, 32'hAC47FFFC, 1, 7, 32'hBEEF, 0); tick();
    chk("sw_rdata2_byp", ex_rdata2_a, 32'hBEEF);
    chk("sw_imm", ex_imm_a, 32'hFFFFFFFC);
    chk("sw_ctrl", ex_ctrl_a, 9'h006);
    chk("sw_rdata2_nobyp", ex_rdata2_b, 32'h1111);

    // lw r4,0(r1) then add r6,r4,r4: one stall, one bubble.
    drive(1, 32'h108, 32'h8C240000, 0, 0, 0, 0); tick();
    drive(1, 32'h10C, 32'h00843020, 0, 0, 0, 0); #1;
    chk("lu_stall", stall_a, 1);
    tick();
    chk("lu_bubble", ex_valid_a, 0);
    chk("lu_bubble_ctrl", ex_ctrl_a, 0);
    #1;
    chk("lu_stall_clear", stall_a, 0);
    tick();
    chk("lu_issue_valid", ex_valid_a, 1);
    chk("lu_issue_pc", ex_pc_a, 32'h10C);
    chk("lu_issue_rd", ex_rd_a, 6);

    // Flush wins over a hazard; then an illegal opcode.
    drive(1, 32'h110, 32'h8C240000, 0, 0, 0, 0); tick();
    drive(1, 32'h114, 32'h00843020, 0, 0, 0, 1); #1;
    chk("flush_stall", stall_a, 0);
    tick();
    chk("flush_valid", ex_valid_a, 0);
    drive(1, 32'h118, 32'hFC000000, 0, 0, 0, 0); tick();
    chk("ill_flag", ex_illegal_a, 1);
    chk("ill_ctrl", ex_ctrl_a, 0);
    chk("ill_valid", ex_valid_a, 1);

    pc = 32'h200;
    drive(1, pc, rand_instr(), 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      if (!m_last_stall) begin
        pc += 4;
        if_valid = ($urandom_range(0, 99) < 85);
        if_pc    = pc;
        if_instr = rand_instr();
      end
      wb_we   = $urandom_range(0, 1) == 1;
      wb_reg  = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      wb_data = $urandom;
      flush   = ($urandom_range(0, 9) == 0);
      tick();
    end

    // Mid-stream asynchronous reset clears outputs and the register file.
    drive(0, 0, 0, 1, 5, 32'h5555, 0); tick();
    drive(0, 0, 0, 1, 9, 32'h9999, 0); tick();
    drive(1, 32'h300, 32'h00A01820, 0, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", ex_valid_a, 0);
    chk("arst_pc", ex_pc_a, 0);
    chk("arst_rdata1", ex_rdata1_a, 0);
    chk("arst_imm", ex_imm_a, 0);
    chk("arst_rd", ex_rd_a, 0);
    chk("arst_stall", stall_a, 0);
    #2 reset = 1'b0;
    tick();
    chk("post_rst_valid", ex_valid_a, 1);
    chk("post_rst_r5", ex_rdata1_a, 0);
    drive(0, 0, 0, 1, 0, 32'hFFFF, 0); tick();
    drive(1, 32'h304, 32'h00001820, 1, 0, 32'hABCD, 0); tick();
    chk("r0_rdata1", ex_rdata1_a, 0);
    chk("r0_rdata2", ex_rdata2_a, 0);
    drive(0, 0, 0, 0, 0, 0, 0); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
